// File: rtl/connect_n_pkg.sv
// Shared types for the Connect-N engine: cell owners, FSM states, scan directions.
// Direction k steps by (DIR_DR[k], DIR_DC[k]) rows/cols; row 0 is the bottom of the board.
package connect_n_pkg;

    localparam int MAX_DIM = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P0    = 2'd1,
        P1    = 2'd2,
        P2    = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WIN   = 2'd2,
        DRAW  = 2'd3
    } state_t;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_H  = 2'd0;
    localparam dir_t DIR_UL = 2'd3;

    // horizontal, vertical, diagonal up-right, diagonal up-left
    localparam int DIR_DR [4] = '{0, 1, 1,  1};
    localparam int DIR_DC [4] = '{1, 0, 1, -1};

    typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][1:0] board_t;

    function automatic logic [1:0] next_player(input logic [1:0] p, input int n);
        return (int'(p) >= n - 1) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/connect_n_engine_line_counter.sv
// Combinational run length through (row,col) along one direction, both sides, each side
// walking at most WIN_LEN-1 cells; zero latency, no handshake.
module line_counter
    import connect_n_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4,
    parameter int CNT_W   = $clog2(2 * WIN_LEN)
) (
    input  board_t             i_board,
    input  logic [3:0]         i_row,
    input  logic [3:0]         i_col,
    input  dir_t               i_dir,
    input  logic [1:0]         i_owner,
    output logic [CNT_W-1:0]   o_count
);

    always_comb begin
        logic [CNT_W-1:0] cnt;
        logic             run;
        int               r;
        int               c;
        cnt = CNT_W'(1);
        run = 1'b0;
        r   = 0;
        c   = 0;
        for (int side = 0; side < 2; side++) begin
            run = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                r = int'(i_row) + ((side == 0) ? k : -k) * DIR_DR[i_dir];
                c = int'(i_col) + ((side == 0) ? k : -k) * DIR_DC[i_dir];
                // the first off-board or foreign cell ends this side's walk
                if (run && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                    i_board[r[3:0]][c[3:0]] == i_owner) begin
                    cnt = cnt + 1'b1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        o_count = cnt;
    end

endmodule

// File: rtl/connect_n_engine.sv
// Connect-N engine: drops tokens, scans one direction per cycle, drives the LED planes.
// Legal move resolves 1..4 cycles after accept; move_ready only in IDLE, other requests ignored.
module connect_n_engine
    import connect_n_pkg::*;
#(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int WIN_LEN     = 4,
    parameter int NUM_PLAYERS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_game,
    input  logic                    move_valid,
    input  logic [$clog2(COLS)-1:0] move_col,
    output logic                    move_ready,
    output logic                    move_done,
    output logic                    illegal_move,
    output logic [1:0]              cur_player,
    output logic                    game_over,
    output logic [1:0]              winner,
    output logic                    draw,
    output logic [8:0]              move_count,
    output logic [15:0][15:0]       RedPixels,
    output logic [15:0][15:0]       GrnPixels
);

    localparam int         CNT_W = $clog2(2 * WIN_LEN);
    localparam logic [8:0] CELLS = 9'(ROWS * COLS);

    state_t                   r_state;
    state_t                   w_state_nxt;
    board_t                   r_board;
    logic [MAX_DIM-1:0][4:0]  r_height;
    logic [3:0]               r_row;
    logic [3:0]               r_col;
    dir_t                     r_dir;
    logic [1:0]               r_cur_player;
    logic [1:0]               r_start_player;
    logic [8:0]               r_move_count;
    logic [1:0]               r_winner;
    logic                     r_draw;
    logic                     r_game_over;
    logic                     r_move_done;
    logic                     r_illegal;
    logic                     r_move_ready;
    logic [15:0][15:0]        r_red;
    logic [15:0][15:0]        r_grn;

    logic [3:0]               w_col4;
    logic [4:0]               w_height;
    logic                     w_accept;
    logic                     w_legal;
    logic                     w_win;
    logic [CNT_W-1:0]         w_count;

    assign w_col4   = 4'(move_col);
    assign w_height = r_height[w_col4];
    assign w_accept = (r_state == IDLE) && move_valid;
    assign w_legal  = (int'(move_col) < COLS) && (w_height != 5'(ROWS));
    assign w_win    = (int'(w_count) >= WIN_LEN);

    line_counter #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN),
        .CNT_W   (CNT_W)
    ) u_line_counter (
        .i_board (r_board),
        .i_row   (r_row),
        .i_col   (r_col),
        .i_dir   (r_dir),
        .i_owner (r_cur_player + 2'd1),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_legal) w_state_nxt = CHECK;
                end
                CHECK: begin
                    if (w_win) begin
                        w_state_nxt = WIN;
                    end else if (r_dir == DIR_UL) begin
                        w_state_nxt = (r_move_count == CELLS) ? DRAW : IDLE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_board        <= '0;
            r_height       <= '0;
            r_row          <= '0;
            r_col          <= '0;
            r_dir          <= DIR_H;
            r_cur_player   <= 2'd0;
            r_start_player <= 2'd0;
            r_move_count   <= '0;
            r_winner       <= 2'd0;
            r_draw         <= 1'b0;
            r_game_over    <= 1'b0;
            r_move_done    <= 1'b0;
            r_illegal      <= 1'b0;
            r_move_ready   <= 1'b1;
            r_red          <= '0;
            r_grn          <= '0;
        end else if (new_game) begin
            r_state        <= IDLE;
            r_board        <= '0;
            r_height       <= '0;
            r_dir          <= DIR_H;
            r_start_player <= next_player(r_start_player, NUM_PLAYERS);
            r_cur_player   <= next_player(r_start_player, NUM_PLAYERS);
            r_move_count   <= '0;
            r_winner       <= 2'd0;
            r_draw         <= 1'b0;
            r_game_over    <= 1'b0;
            r_move_done    <= 1'b0;
            r_illegal      <= 1'b0;
            r_move_ready   <= 1'b1;
            r_red          <= '0;
            r_grn          <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_move_ready <= (w_state_nxt == IDLE);
            r_move_done  <= 1'b0;
            r_illegal    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_legal) begin
                        r_illegal <= 1'b1;
                    end else if (w_accept) begin
                        r_board[w_height[3:0]][w_col4] <= 2'(P0) + r_cur_player;
                        r_height[w_col4]               <= w_height + 5'd1;
                        r_move_count                   <= r_move_count + 9'd1;
                        r_row                          <= w_height[3:0];
                        r_col                          <= w_col4;
                        r_dir                          <= DIR_H;
                        // player0 red, player1 green, player2 both
                        r_red[4'd15 - w_height[3:0]][w_col4] <= (r_cur_player != 2'd1);
                        r_grn[4'd15 - w_height[3:0]][w_col4] <= (r_cur_player != 2'd0);
                    end
                end
                CHECK: begin
                    r_dir <= r_dir + 2'd1;
                    if (w_win) begin
                        r_winner    <= r_cur_player + 2'd1;
                        r_game_over <= 1'b1;
                        r_move_done <= 1'b1;
                    end else if (r_dir == DIR_UL) begin
                        r_move_done <= 1'b1;
                        if (r_move_count == CELLS) begin
                            r_draw      <= 1'b1;
                            r_game_over <= 1'b1;
                        end else begin
                            r_cur_player <= next_player(r_cur_player, NUM_PLAYERS);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign move_ready   = r_move_ready;
    assign move_done    = r_move_done;
    assign illegal_move = r_illegal;
    assign cur_player   = r_cur_player;
    assign game_over    = r_game_over;
    assign winner       = r_winner;
    assign draw         = r_draw;
    assign move_count   = r_move_count;
    assign RedPixels    = r_red;
    assign GrnPixels    = r_grn;

endmodule

// File: tb/tb_connect_n_engine.sv
// Scoreboarded bench: 8x8/4-in-a-row/2-player engine plus a 4x5/6-in-a-row/3-player engine.
module tb_connect_n_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel;
    logic       tb_valid;
    logic       tb_ng;
    logic [3:0] tb_col;

    logic ng1, mv1, rdy1, done1, ill1, over1, draw1;
    logic [2:0] col1;
    logic [1:0] cp1, win1;
    logic [8:0] cnt1;
    logic [15:0][15:0] red1, grn1;

    logic ng2, mv2, rdy2, done2, ill2, over2, draw2;
    logic [2:0] col2;
    logic [1:0] cp2, win2;
    logic [8:0] cnt2;
    logic [15:0][15:0] red2, grn2;

    assign ng1  = tb_ng & ~sel;
    assign mv1  = tb_valid & ~sel;
    assign col1 = tb_col[2:0];
    assign ng2  = tb_ng & sel;
    assign mv2  = tb_valid & sel;
    assign col2 = tb_col[2:0];

    connect_n_engine #(.COLS(8), .ROWS(8), .WIN_LEN(4), .NUM_PLAYERS(2)) u_dut (
        .clk(clk), .reset(reset), .new_game(ng1), .move_valid(mv1), .move_col(col1),
        .move_ready(rdy1), .move_done(done1), .illegal_move(ill1), .cur_player(cp1),
        .game_over(over1), .winner(win1), .draw(draw1), .move_count(cnt1),
        .RedPixels(red1), .GrnPixels(grn1)
    );

    connect_n_engine #(.COLS(5), .ROWS(4), .WIN_LEN(6), .NUM_PLAYERS(3)) u_dut2 (
        .clk(clk), .reset(reset), .new_game(ng2), .move_valid(mv2), .move_col(col2),
        .move_ready(rdy2), .move_done(done2), .illegal_move(ill2), .cur_player(cp2),
        .game_over(over2), .winner(win2), .draw(draw2), .move_count(cnt2),
        .RedPixels(red2), .GrnPixels(grn2)
    );

    logic m_ready, m_done, m_ill, m_over, m_draw;
    logic [1:0] m_cp, m_win;
    logic [8:0] m_cnt;
    logic [15:0][15:0] m_red, m_grn;

    always_comb begin
        if (sel) begin
            m_ready = rdy2; m_done = done2; m_ill = ill2; m_over = over2; m_draw = draw2;
            m_cp = cp2; m_win = win2; m_cnt = cnt2; m_red = red2; m_grn = grn2;
        end else begin
            m_ready = rdy1; m_done = done1; m_ill = ill1; m_over = over1; m_draw = draw1;
            m_cp = cp1; m_win = win1; m_cnt = cnt1; m_red = red1; m_grn = grn1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- reference model: the game as plain arrays ----------------
    int g_rows, g_cols, g_win, g_np;
    int mb [16][16];
    int mh [16];
    int m_cur, m_start, m_count, m_winner;
    bit m_over_b, m_draw_b;
    int DR [4] = '{0, 1, 1, 1};
    int DC [4] = '{1, 0, 1, -1};

    typedef struct {
        bit           illegal;
        int           cyc;
        int           winner;
        bit           draw;
        bit           over;
        int           cur;
        int           cnt;
        logic [255:0] red;
        logic [255:0] grn;
    } exp_t;

    exp_t q[$];

    task automatic model_clear();
        for (int r = 0; r < 16; r++) begin
            mh[r] = 0;
            for (int c = 0; c < 16; c++) mb[r][c] = 0;
        end
        m_count = 0; m_winner = 0; m_over_b = 0; m_draw_b = 0;
    endtask

    task automatic model_new_game();
        m_start = (m_start + 1) % g_np;
        m_cur   = m_start;
        model_clear();
    endtask

    function automatic int run_from(int r, int c, int dr, int dc, int own);
        int n  = 0;
        int rr = r + dr;
        int cc = c + dc;
        while (rr >= 0 && rr < g_rows && cc >= 0 && cc < g_cols && mb[rr][cc] == own) begin
            n++; rr += dr; cc += dc;
        end
        return n;
    endfunction

    task automatic model_planes(output logic [255:0] red, output logic [255:0] grn);
        logic [15:0][15:0] pr, pg;
        pr = '0; pg = '0;
        for (int r = 0; r < g_rows; r++)
            for (int c = 0; c < g_cols; c++) begin
                pr[15-r][c] = (mb[r][c] == 1 || mb[r][c] == 3);
                pg[15-r][c] = (mb[r][c] == 2 || mb[r][c] == 3);
            end
        red = pr; grn = pg;
    endtask

    // lat = clock edges after the accept edge until the pulse is on the outputs' register
    task automatic model_move(input int col, output exp_t e);
        int lat, r, own, wd, n;
        e.illegal = (col >= g_cols) || (mh[col] == g_rows);
        lat = 0;
        if (!e.illegal) begin
            r = mh[col]; own = m_cur + 1;
            mb[r][col] = own; mh[col]++; m_count++;
            wd = -1;
            for (int d = 0; d < 4; d++) begin
                n = 1 + run_from(r, col, DR[d], DC[d], own) + run_from(r, col, -DR[d], -DC[d], own);
                if (n >= g_win && wd < 0) wd = d;
            end
            if (wd >= 0) begin
                m_winner = own; m_over_b = 1; lat = wd + 1;
            end else begin
                lat = 4;
                if (m_count == g_rows * g_cols) begin
                    m_draw_b = 1; m_over_b = 1;
                end else begin
                    m_cur = (m_cur + 1) % g_np;
                end
            end
        end
        e.cyc = cyc + 1 + lat;
        e.winner = m_winner; e.draw = m_draw_b; e.over = m_over_b;
        e.cur = m_cur; e.cnt = m_count;
        model_planes(e.red, e.grn);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && (m_done || m_ill)) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pulse done=%0d illegal=%0d required=none (cycle %0d)", m_done, m_ill, cyc);
            end else begin
                e = q.pop_front();
                chk("illegal_pulse", m_ill, e.illegal);
                chk("done_pulse", m_done, !e.illegal);
                chk("pulse_cycle", cyc, e.cyc);
                chk("winner", m_win, e.winner);
                chk("draw", m_draw, e.draw);
                chk("game_over", m_over, e.over);
                chk("cur_player", m_cp, e.cur);
                chk("move_count", m_cnt, e.cnt);
                chk("move_ready", m_ready, !e.over);
                chk("red_plane", m_red, e.red);
                chk("grn_plane", m_grn, e.grn);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_move(input int col, input bit junk);
        exp_t e;
        int n;
        n = 0;
        while (!m_ready && n < 50) begin @(negedge clk); n++; end
        if (!m_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        model_move(col, e);
        q.push_back(e);
        tb_col = 4'(col); tb_valid = 1'b1;
        @(negedge clk);
        if (e.illegal || !junk) begin
            tb_valid = 1'b0;
        end else begin
            // keep requesting while busy; these must be ignored
            n = 0;
            while (!(m_done || m_ill) && n < 8) begin
                tb_col = 4'($urandom_range(0, 7));
                @(negedge clk); n++;
            end
            tb_valid = 1'b0;
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            chk("response_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_new_game();
        tb_ng = 1'b1;
        model_new_game();
        @(negedge clk);
        tb_ng = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int diag_cols [11] = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 5, 3};
        logic [3:0] nib;
        int col;
        reset = 1'b1; sel = 1'b0; tb_valid = 1'b0; tb_ng = 1'b0; tb_col = '0;
        g_rows = 8; g_cols = 8; g_win = 4; g_np = 2;
        m_start = 0; m_cur = 0; model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk("rst_red", m_red, '0);
        chk("rst_grn", m_grn, '0);
        chk("rst_cur_player", m_cp, 0);
        chk("rst_move_ready", m_ready, 1);
        chk("rst_winner", m_win, 0);
        chk("rst_move_count", m_cnt, 0);
        chk("rst_game_over", m_over, 0);
        chk("rst_draw", m_draw, 0);
        chk("rst_pulses", {m_done, m_ill}, 0);
        mon_en = 1'b1;

        // new_game in the middle of CHECK drops the move
        tb_col = 4'd3; tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0;
        do_new_game();
        chk("ng_mid_cur_player", m_cp, 1);
        chk("ng_mid_move_count", m_cnt, 0);
        chk("ng_mid_red", m_red, '0);
        chk("ng_mid_ready", m_ready, 1);
        do_new_game();
        chk("ng2_cur_player", m_cp, 0);

        // vertical win in column 0
        foreach (diag_cols[i]) if (i < 7) do_move((i % 2 == 0) ? 0 : 1, 1'b1);
        nib = {m_red[15][0], m_red[14][0], m_red[13][0], m_red[12][0]};
        chk("vwin_red_col0", nib, 4'hF);
        chk("vwin_game_over", m_over, 1);
        chk("vwin_winner", m_win, 1);
        chk("vwin_ready", m_ready, 0);
        tb_col = 4'd2; tb_valid = 1'b1;
        repeat (3) @(negedge clk);
        tb_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("after_win_move_count", m_cnt, 7);

        // fill column 2, then overfill it
        do_new_game();
        for (int i = 0; i < 8; i++) do_move(2, 1'b0);
        chk("fill_move_count", m_cnt, 8);
        do_move(2, 1'b0);

        // diagonal up-right win
        do_new_game();
        foreach (diag_cols[i]) do_move(diag_cols[i], 1'b0);
        chk("diag_winner", m_win, 1);

        // random games
        for (int g = 0; g < 25; g++) begin
            do_new_game();
            for (int m = 0; m < 70 && !m_over_b; m++) begin
                col = ($urandom % 3 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
                do_move(col, 1'($urandom % 2));
            end
        end

        // 4x5 board, 3 players, no line of 6 possible: ends in a draw
        sel = 1'b1;
        g_rows = 4; g_cols = 5; g_win = 6; g_np = 3;
        m_start = 0; m_cur = 0; model_clear();
        @(negedge clk);
        do_move(5, 1'b0);
        do_move(7, 1'b0);
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 4; k++) do_move(c, 1'($urandom % 2));
            if (c == 0) do_move(0, 1'b0);
        end
        chk("draw_flag", m_draw, 1);
        chk("draw_game_over", m_over, 1);
        chk("draw_winner", m_win, 0);
        chk("draw_move_count", m_cnt, 20);
        do_new_game();
        chk("p3_ng_cur_player", m_cp, 1);
        chk("p3_ng_grn", m_grn, '0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
